// File: rtl/dc_bsp_pkg.sv
// Shared board-support constants: interrupt source bit positions, IRQ CSR word map
// and the host-interrupt FSM state type.
package dc_bsp_pkg;

    localparam int BSP_AVMM_NUM_IRQ_USED   = 3;
    localparam int BSP_NUM_INTERRUPT_LINES = 4;

    localparam int BSP_DMA_0_IRQ_BIT  = 0;
    localparam int BSP_KERNEL_IRQ_BIT = 1;
    localparam int BSP_DMA_1_IRQ_BIT  = 2;

    localparam logic [1:0] IRQ_CSR_STATUS = 2'd0;
    localparam logic [1:0] IRQ_CSR_ENABLE = 2'd1;
    localparam logic [1:0] IRQ_CSR_RAW    = 2'd2;
    localparam logic [1:0] IRQ_CSR_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } t_irq_state;

endpackage

// File: rtl/asp_irq_rr_arb.sv
// N-way round-robin arbiter. The pointer holds the index where the next search
// starts; it moves to one past the winner whenever a grant is taken.
module asp_irq_rr_arb #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             update,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;

    function automatic int wrap_idx(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!any && req[wrap_idx(int'(ptr) + off)]) begin
                any                             = 1'b1;
                grant[wrap_idx(int'(ptr) + off)] = 1'b1;
                grant_idx                       = IDX_W'(wrap_idx(int'(ptr) + off));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (update && any) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/asp_irq_ctrl.sv
// Host interrupt controller: sticky pending bits, enable mask, one vectored request
// outstanding at a time with ack tracking, and a 64-bit MMIO CSR slave.
module asp_irq_ctrl
    import dc_bsp_pkg::*;
#(
    parameter int NUM_IRQ_USED = BSP_AVMM_NUM_IRQ_USED,
    parameter int NUM_VECTORS  = BSP_NUM_INTERRUPT_LINES,
    parameter logic [NUM_IRQ_USED-1:0] LEVEL_MASK = NUM_IRQ_USED'(1 << BSP_KERNEL_IRQ_BIT),
    localparam int VEC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    localparam int IDX_W = (NUM_IRQ_USED > 1) ? $clog2(NUM_IRQ_USED) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IRQ_USED-1:0] irq_in,
    output logic                    irq_req_valid,
    output logic [VEC_W-1:0]        irq_req_vector,
    input  logic                    irq_req_ready,
    input  logic                    irq_ack,
    input  logic [1:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [63:0]             avs_writedata,
    input  logic [7:0]              avs_byteenable,
    output logic [63:0]             avs_readdata,
    output logic                    avs_readdatavalid,
    output logic                    avs_waitrequest
);

    localparam int N = NUM_IRQ_USED;

    t_irq_state  state;
    logic [N-1:0] irq_s, irq_d;
    logic [N-1:0] pending, sent, enable;
    logic [31:0]  sent_count;

    logic [N-1:0]     set_term, clr, accept_mask, eligible;
    logic [N-1:0]     unused_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any, accept, wr_ok;
    logic [63:0]      rd_word;
    logic             unused_bits;

    assign avs_waitrequest = 1'b0;
    assign unused_bits     = ^{avs_writedata[63:N], avs_byteenable[7:1]};

    // Level sources set every cycle they are high; edge sources only on a new rise.
    assign set_term = irq_s & (LEVEL_MASK | ~irq_d);
    assign wr_ok    = avs_write && avs_byteenable[0];
    assign clr      = (wr_ok && avs_address == IRQ_CSR_STATUS) ? avs_writedata[N-1:0] : '0;
    assign accept   = irq_req_valid && irq_req_ready;
    assign eligible = pending & enable & ~sent;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            accept_mask[i] = accept && (irq_req_vector == VEC_W'(i));
        end
    end

    asp_irq_rr_arb #(.N(N), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (eligible),
        .update    (state == IDLE),
        .grant     (unused_grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Set beats a same-cycle W1C on pending; W1C always clears sent so a still-high
    // level source can fire again.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_s      <= '0;
            irq_d      <= '0;
            pending    <= '0;
            sent       <= '0;
            enable     <= '0;
            sent_count <= '0;
        end else begin
            irq_s   <= irq_in;
            irq_d   <= irq_s;
            pending <= (pending & ~clr) | set_term;
            sent    <= (sent & ~clr) | accept_mask;
            if (wr_ok && avs_address == IRQ_CSR_ENABLE) begin
                enable <= avs_writedata[N-1:0];
            end
            if (accept && sent_count != 32'hFFFF_FFFF) begin
                sent_count <= sent_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            irq_req_valid  <= 1'b0;
            irq_req_vector <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        irq_req_vector <= VEC_W'(grant_idx);
                        irq_req_valid  <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (irq_req_ready) begin
                        irq_req_valid <= 1'b0;
                        state         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (irq_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    irq_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (avs_address)
            IRQ_CSR_STATUS: rd_word[N-1:0] = pending;
            IRQ_CSR_ENABLE: rd_word[N-1:0] = enable;
            IRQ_CSR_RAW:    rd_word[N-1:0] = irq_s;
            default:        rd_word[31:0]  = sent_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Directed bench for asp_irq_ctrl: stimulus pushes expected request vectors and CSR
// read data into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_asp_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  irq_in;
    logic        irq_req_valid;
    logic [1:0]  irq_req_vector;
    logic        irq_req_ready;
    logic        irq_ack;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [63:0] avs_writedata;
    logic [7:0]  avs_byteenable;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;

    logic [1:0]  exp_vec_q[$];
    logic [63:0] exp_rd_q[$];
    int checks = 0;
    int errors = 0;

    asp_irq_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .irq_in            (irq_in),
        .irq_req_valid     (irq_req_valid),
        .irq_req_vector    (irq_req_vector),
        .irq_req_ready     (irq_req_ready),
        .irq_ack           (irq_ack),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (irq_req_valid && irq_req_ready) begin
            if (exp_vec_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got vector %0d required no request", irq_req_vector);
            end else begin
                check("req_vector", 64'(irq_req_vector), 64'(exp_vec_q.pop_front()));
            end
        end
        if (avs_readdatavalid) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h required no read data", avs_readdata);
            end else begin
                check("csr_readdata", avs_readdata, exp_rd_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [63:0] data);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = 8'hFF;
        avs_write      = 1'b1;
        tick(1);
        avs_write      = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] addr, input logic [63:0] exp);
        exp_rd_q.push_back(exp);
        avs_address = addr;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
    endtask

    task automatic pulse(input logic [2:0] mask);
        irq_in = irq_in | mask;
        tick(1);
        irq_in = irq_in & ~mask;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!irq_req_valid && n < 20) begin
            tick(1);
            n++;
        end
        check(name, 64'(irq_req_valid), 64'd1);
    endtask

    task automatic ack_after_accept();
        tick(1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic serve(input string name);
        wait_valid(name);
        ack_after_accept();
    endtask

    task automatic expect_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tick(1);
            check(name, 64'(irq_req_valid), 64'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0; irq_in = '0; irq_req_ready = 1'b1; irq_ack = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        tick(3);
        reset_n = 1'b1;
        check("rst_valid", 64'(irq_req_valid), 64'd0);
        check("rst_vector", 64'(irq_req_vector), 64'd0);
        check("rst_readdata", avs_readdata, 64'd0);
        check("rst_rdvalid", 64'(avs_readdatavalid), 64'd0);
        check("waitrequest", 64'(avs_waitrequest), 64'd0);
        for (int a = 0; a < 4; a++) csr_read(2'(a), 64'd0);

        // DMA_0 edge path with exact latency
        csr_write(1, 64'h7);
        exp_vec_q.push_back(2'd0);
        pulse(3'b001);
        tick(1);
        check("dma0_latency_early", 64'(irq_req_valid), 64'd0);
        tick(1);
        check("dma0_latency_k2", 64'(irq_req_valid), 64'd1);
        check("dma0_vector", 64'(irq_req_vector), 64'd0);
        ack_after_accept();
        csr_read(0, 64'h1);
        pulse(3'b001);
        expect_idle(4, "dma0_no_refire");
        csr_write(0, 64'h1);
        exp_vec_q.push_back(2'd0);
        pulse(3'b001);
        serve("dma0_refire");
        csr_read(3, 64'd2);
        csr_write(0, 64'h1);

        // Kernel level re-fire after W1C
        csr_write(1, 64'h2);
        exp_vec_q.push_back(2'd1);
        irq_in[1] = 1'b1;
        serve("kernel_first");
        expect_idle(4, "kernel_no_refire");
        csr_read(0, 64'h2);
        csr_read(2, 64'h2);
        exp_vec_q.push_back(2'd1);
        csr_write(0, 64'h2);
        serve("kernel_refire");
        csr_read(0, 64'h2);
        irq_in[1] = 1'b0;
        tick(3);
        csr_write(0, 64'h2);
        csr_read(0, 64'h0);
        csr_read(3, 64'd4);

        // Masking: pending while disabled, fires once enabled
        csr_write(1, 64'h0);
        pulse(3'b100);
        expect_idle(4, "mask_no_req");
        csr_read(0, 64'h4);
        exp_vec_q.push_back(2'd2);
        csr_write(1, 64'h4);
        check("mask_enable_early", 64'(irq_req_valid), 64'd0);
        tick(1);
        check("mask_enable_valid", 64'(irq_req_valid), 64'd1);
        check("mask_enable_vector", 64'(irq_req_vector), 64'd2);
        ack_after_accept();
        csr_write(0, 64'h4);

        // Backpressure with a stray ack during REQ
        csr_write(1, 64'h7);
        irq_req_ready = 1'b0;
        exp_vec_q.push_back(2'd0);
        pulse(3'b001);
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) irq_ack = 1'b1;
            tick(1);
            irq_ack = 1'b0;
            check("bp_valid_hold", 64'(irq_req_valid), 64'd1);
            check("bp_vector_hold", 64'(irq_req_vector), 64'd0);
        end
        irq_req_ready = 1'b1;
        tick(1);
        check("bp_released", 64'(irq_req_valid), 64'd0);
        csr_read(3, 64'd6);

        // Reset while waiting for ack
        reset_n = 1'b0;
        tick(1);
        check("rst_mid_valid", 64'(irq_req_valid), 64'd0);
        check("rst_mid_vector", 64'(irq_req_vector), 64'd0);
        reset_n = 1'b1;
        csr_read(0, 64'h0);
        csr_read(1, 64'h0);
        csr_read(3, 64'h0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        expect_idle(3, "rst_stray_ack");

        // Round-robin from a fresh pointer
        csr_write(1, 64'h7);
        exp_vec_q.push_back(2'd0);
        exp_vec_q.push_back(2'd1);
        exp_vec_q.push_back(2'd2);
        pulse(3'b111);
        serve("rr_first");
        serve("rr_second");
        serve("rr_third");
        csr_write(0, 64'h7);
        exp_vec_q.push_back(2'd0);
        exp_vec_q.push_back(2'd2);
        pulse(3'b101);
        serve("rr_wrap_a");
        serve("rr_wrap_b");
        csr_read(3, 64'd5);

        tick(3);
        check("req_queue_drained", 64'(exp_vec_q.size()), 64'd0);
        check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/asp_irq_ctrl.md
# asp_irq_ctrl

Interrupt controller for the OpenCL ASP's host interrupt path. It collects the three used interrupt sources (DMA_0, kernel, DMA_1) into sticky pending bits and applies a host-programmable enable mask. Each enabled pending source is forwarded as a single vectored interrupt request to the FIM/PIM interrupt interface, with one request outstanding at a time and acknowledge tracking. It sits between the DMA controllers and kernel-system IRQ outputs and the host interrupt port, and exposes a 64-bit MMIO CSR slave on the board.qsys MMIO64 bus.

## Interface

Parameters:
- NUM_IRQ_USED, default BSP_AVMM_NUM_IRQ_USED (3): number of interrupt sources.
- NUM_VECTORS, default BSP_NUM_INTERRUPT_LINES (4): host vectors. Source i maps to vector i. Vectors at or above NUM_IRQ_USED are never issued.
- LEVEL_MASK, default 3'b010: per-source mode. 1 = level (kernel), 0 = rising-edge (DMA).

Ports:
- clk, in, 1: single clock for all logic.
- reset_n, in, 1: reset, synchronous and active-low.
- irq_in, in, NUM_IRQ_USED: raw sources. Bit 0 DMA_0, bit 1 kernel, bit 2 DMA_1. Synchronous to clk.
- irq_req_valid, out, 1: interrupt request valid.
- irq_req_vector, out, $clog2(NUM_VECTORS): vector ID of the request.
- irq_req_ready, in, 1: fabric accepts the request.
- irq_ack, in, 1: one-cycle pulse; the host has serviced the outstanding request.
- avs_address, in, 2: 64-bit word address.
- avs_read, in, 1; avs_write, in, 1.
- avs_writedata, in, 64; avs_byteenable, in, 8.
- avs_readdata, out, 64; avs_readdatavalid, out, 1.
- avs_waitrequest, out, 1: tied 0.

## Operation

CSR map:
- Word 0, STATUS[2:0]: pending bits. Reads return the value; writing 1 clears (W1C).
- Word 1, ENABLE[2:0]: read/write, reset value 0.
- Word 2, RAW[2:0]: current irq_s levels, read-only.
- Word 3, SENT_COUNT[31:0]: total accepted requests, saturates at 0xFFFF_FFFF, read-only.
- Unused bits read 0. Writes to read-only words are ignored. A write takes effect only if byteenable[0] (bits 7:0) is set.

Sources:
- irq_in is registered into irq_s, then into irq_d.
- Edge-mode set term: irq_s & ~irq_d.
- Level-mode set term: irq_s.
- When a set and a W1C clear hit the same bit in the same cycle, the set wins.

Sent flags (sent[i]):
- sent[i] is set when the request for source i is accepted (valid & ready).
- sent[i] is cleared by a W1C to STATUS bit i, even if pending re-sets in the same cycle. This lets a level source that is still high re-fire.

Eligibility:
- A source is eligible when pending & ENABLE & ~sent.
- Eligibility is evaluated after the enable mask. Enabling an already-pending, unsent bit fires it.

FSM (reset state IDLE):
- IDLE: if any source is eligible, a round-robin grant picks it (search starts after the last granted index; reset pointer 0). Latch the vector, go to REQ.
- REQ: irq_req_valid = 1 and irq_req_vector is held stable until ready. On valid & ready: set sent, increment SENT_COUNT, go to WAIT_ACK.
- WAIT_ACK: on irq_ack go to IDLE. An irq_ack seen in IDLE or REQ is ignored.
- Disabling or clearing a source while in REQ does not withdraw the request.

## Timing

- Reset (synchronous, active-low), sampled on a rising clk edge: all registers go to 0 at that edge. Outputs after reset: irq_req_valid 0, irq_req_vector 0, avs_readdata 0, avs_readdatavalid 0.
- Reset asserted during REQ or WAIT_ACK drops valid at the next edge; any outstanding ack is forgotten.
- Source latency: irq_in rises before edge k → irq_s high at k → pending at k+1 → irq_req_valid high at k+2, provided the FSM is IDLE and the source is enabled.
- Back-to-back requests: the next request is issued at the earliest 1 cycle after the irq_ack edge (WAIT_ACK → IDLE → REQ).
- CSR reads: readdatavalid and readdata arrive 1 cycle after avs_read. readdata is held between reads.
- CSR writes: effective at the next edge. A W1C write and a read in the same cycle return the pre-clear value.

## Structure

- Add to dc_bsp_pkg:
  - CSR word offsets as localparams: IRQ_CSR_STATUS=0, IRQ_CSR_ENABLE=1, IRQ_CSR_RAW=2, IRQ_CSR_COUNT=3.
  - The FSM state enum t_irq_state {IDLE, REQ, WAIT_ACK}.
- Source bit indices come from the existing BSP_DMA_0_IRQ_BIT, BSP_KERNEL_IRQ_BIT and BSP_DMA_1_IRQ_BIT.
- Sub-module asp_irq_rr_arb: N-way round-robin arbiter with request vector, grant one-hot and last-grant pointer update.

## Test plan

- **DMA_0 edge path:** ENABLE=0x7, one-cycle pulse on irq_in[0] → valid at k+2 with vector 0, STATUS=0x1. After ready, a second pulse does not re-fire. W1C 0x1 then another pulse → fires again; SENT_COUNT=2.
- **Kernel level re-fire:** irq_in[1] held high, ENABLE=0x2 → one request (vector 1). After ack, W1C 0x2 → STATUS stays 0x2 and a second request on vector 1 issues.
- **Round-robin:** all three sources pulse in the same cycle with ENABLE=0x7, acking each → vectors issue in order 0, 1, 2. Then pulse 0 and 2 together → vector 0 first only if the pointer has wrapped; otherwise the search order from the pointer applies (expected order 0 then 2).
- **Masking:** source 2 pulses with ENABLE=0 → STATUS=0x4 and no valid. Write ENABLE=0x4 → valid with vector 2 two cycles later.
- **Backpressure and stray ack:** hold irq_req_ready=0 for 10 cycles → valid and vector stay stable. Inject irq_ack in REQ → ignored; FSM remains in REQ.
- **Reset mid-WAIT_ACK:** reset_n low for 1 cycle → STATUS=0, ENABLE=0, SENT_COUNT=0 and valid=0 at the next edge. A subsequent irq_ack has no effect.
